cpu_writeback: RTL and testbench

Writeback stage and architectural state holder directly downstream of the ALU. It accepts one ALU result per handshake and commits it to the 8×16 general register file. It updates the 8-bit status register from ALU flags or from flag set/clear opcodes, and it sequences the two-word MUL result over two cycles. It also supplies the two combinational register read ports that feed the ALU's rs1data/rs2data.

---
 rtl/cpu_writeback_if.sv | 22 ++
 rtl/cpu_writeback.sv | 109 ++++++++++
 tb/tb_cpu_writeback.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_writeback_if.sv
// Writeback handshake bundle between the ALU (master) and the writeback stage (slave).
// A result transfers on a rising edge where wb_valid && wb_ready; the master holds payload until then.
interface cpu_writeback_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [5:0]  encoded_opcode;
  logic [2:0]  reg_write_addr;
  logic [15:0] aluout1;
  logic [15:0] aluout2;
  logic [7:0]  statusregin;
  logic        wb_done;

  modport master (
    output wb_valid, encoded_opcode, reg_write_addr, aluout1, aluout2, statusregin,
    input  wb_ready, wb_done
  );

  modport slave (
    input  wb_valid, encoded_opcode, reg_write_addr, aluout1, aluout2, statusregin,
    output wb_ready, wb_done
  );
endinterface

// File: rtl/cpu_writeback.sv
// Writeback stage: commits ALU results to the 8x16 register file, maintains the status
// register, sequences the two-word MUL result, and serves two combinational read ports.
module cpu_writeback (
  input  logic              clk,
  input  logic              reset,
  cpu_writeback_if.slave    wb,
  input  logic [2:0]        reg_read_addr,
  input  logic [2:0]        reg_read_addr2,
  output logic [15:0]       rs1data,
  output logic [15:0]       rs2data,
  output logic [7:0]        statusreg,
  output logic              state_dbg
);

  localparam logic [5:0] OP_MUL = 6'h21;

  typedef enum logic {IDLE = 1'b0, MUL_HI = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] regs [8];
  logic [15:0] hi_word_q;
  logic [2:0]  hi_addr_q;
  logic [7:0]  status_q;
  logic        done_q, done_d;
  logic        accept;
  logic        wr_en, flag_en;
  logic        sc_en, sc_set;
  logic [2:0]  sc_bit;
  logic [5:0]  sc_off;
  logic        unused_bits;

  assign wb.wb_ready = (state_q == IDLE);
  assign wb.wb_done  = done_q;
  assign accept      = wb.wb_valid && wb.wb_ready;
  assign statusreg   = status_q;
  assign state_dbg   = state_q;

  // No write bypass: a read of the register being written shows the old value this cycle.
  assign rs1data = regs[reg_read_addr];
  assign rs2data = regs[reg_read_addr2];

  always_comb begin
    wr_en   = 1'b0;
    flag_en = 1'b0;
    case (wb.encoded_opcode) inside
      [6'h03:6'h05], 6'h0B, 6'h0C, [6'h0E:6'h10], 6'h17, 6'h18, 6'h22, OP_MUL:
        wr_en = 1'b1;
      [6'h06:6'h09], [6'h11:6'h14], [6'h1D:6'h1F]: begin
        wr_en   = 1'b1;
        flag_en = 1'b1;
      end
      6'h15, 6'h16, 6'h20:
        flag_en = 1'b1;
      default: ;
    endcase
  end

  // Set/clear opcodes come in pairs starting at 0x29: even offset sets, odd clears.
  assign sc_off      = wb.encoded_opcode - 6'h29;
  assign sc_en       = (wb.encoded_opcode >= 6'h29) && (wb.encoded_opcode <= 6'h36);
  assign sc_bit      = sc_off[3:1];
  assign sc_set      = ~sc_off[0];
  assign unused_bits = ^{wb.statusregin[7:3], sc_off[5:4]};

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (wb.encoded_opcode == OP_MUL) state_d = MUL_HI;
          else                             done_d  = 1'b1;
        end
      end
      MUL_HI: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      hi_word_q <= 16'h0000;
      hi_addr_q <= 3'd0;
      status_q  <= 8'h00;
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == MUL_HI) begin
        regs[hi_addr_q] <= hi_word_q;
      end else if (accept) begin
        if (wr_en) regs[wb.reg_write_addr] <= wb.aluout1;
        if (wb.encoded_opcode == OP_MUL) begin
          hi_word_q <= wb.aluout2;
          hi_addr_q <= wb.reg_write_addr + 3'd1;
        end
        // Bit 7 is never written, so it stays at its reset value of 0.
        if (flag_en)    status_q[2:0]    <= wb.statusregin[2:0];
        else if (sc_en) status_q[sc_bit] <= sc_set;
      end
    end
  end

endmodule

// File: tb/tb_cpu_writeback.sv
// Bench for cpu_writeback: directed vectors, a behavioural model checked every cycle,
// and literal expectations at the scenario points.
module tb_cpu_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  reg_read_addr, reg_read_addr2;
  logic [15:0] rs1data, rs2data;
  logic [7:0]  statusreg;
  logic        state_dbg;

  always #10 clk = ~clk;

  cpu_writeback_if wbi();

  cpu_writeback dut (
    .clk            (clk),
    .reset          (reset),
    .wb             (wbi.slave),
    .reg_read_addr  (reg_read_addr),
    .reg_read_addr2 (reg_read_addr2),
    .rs1data        (rs1data),
    .rs2data        (rs2data),
    .statusreg      (statusreg),
    .state_dbg      (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_regs [8] = '{default: 16'h0000};
  logic [7:0]  m_sr      = 8'h00;
  logic        m_busy    = 1'b0;
  logic [2:0]  m_hi_addr = 3'd0;
  logic [15:0] m_hi_word = 16'h0000;
  logic [31:0] exp_q[$];  // cycle numbers in which wb_done must be high

  function automatic bit m_writes(input logic [5:0] op);
    return op inside {[6'h03:6'h09], 6'h0B, 6'h0C, [6'h0E:6'h14], 6'h17, 6'h18,
                      [6'h1D:6'h1F], 6'h21, 6'h22};
  endfunction

  function automatic bit m_flags(input logic [5:0] op);
    return op inside {[6'h06:6'h09], [6'h11:6'h16], [6'h1D:6'h20]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0000;
      m_sr      <= 8'h00;
      m_busy    <= 1'b0;
      m_hi_addr <= 3'd0;
      m_hi_word <= 16'h0000;
      exp_q.delete();
    end else if (m_busy) begin
      m_regs[m_hi_addr] <= m_hi_word;
      m_busy <= 1'b0;
    end else if (wbi.wb_valid) begin
      if (m_writes(wbi.encoded_opcode)) m_regs[wbi.reg_write_addr] <= wbi.aluout1;
      if (wbi.encoded_opcode == 6'h21) begin
        m_busy    <= 1'b1;
        m_hi_addr <= 3'((int'(wbi.reg_write_addr) + 1) % 8);
        m_hi_word <= wbi.aluout2;
        exp_q.push_back(cyc + 2);
      end else begin
        exp_q.push_back(cyc + 1);
      end
      if (m_flags(wbi.encoded_opcode)) m_sr <= {m_sr[7:3], wbi.statusregin[2:0]};
      for (int b = 0; b < 7; b++) begin
        if (int'(wbi.encoded_opcode) == 'h29 + 2 * b) m_sr[b] <= 1'b1;
        if (int'(wbi.encoded_opcode) == 'h2A + 2 * b) m_sr[b] <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic exp_done;
    check("rs1data", rs1data, m_regs[reg_read_addr]);
    check("rs2data", rs2data, m_regs[reg_read_addr2]);
    check("statusreg", 16'(statusreg), 16'(m_sr));
    check("wb_ready", 16'(wbi.wb_ready), 16'(!m_busy));
    exp_done = (exp_q.size() > 0) && (exp_q[0] == cyc);
    check("wb_done", 16'(wbi.wb_done), 16'(exp_done));
    if (exp_done) void'(exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    reg_read_addr  = reg_read_addr + 3'd1;
    reg_read_addr2 = reg_read_addr2 + 3'd3;
  endtask

  task automatic peek(input string name, input logic [2:0] addr, input logic [15:0] exp);
    reg_read_addr2 = addr;
    #1;
    check(name, rs2data, exp);
  endtask

  task automatic set_in(input logic [5:0] op, input logic [2:0] addr,
                        input logic [15:0] a1, input logic [15:0] a2, input logic [7:0] sr);
    wbi.encoded_opcode = op;
    wbi.reg_write_addr = addr;
    wbi.aluout1        = a1;
    wbi.aluout2        = a2;
    wbi.statusregin    = sr;
    wbi.wb_valid       = 1'b1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [2:0] addr,
                       input logic [15:0] a1, input logic [15:0] a2, input logic [7:0] sr);
    set_in(op, addr, a1, a2, sr);
    tick();
    wbi.wb_valid = 1'b0;
  endtask

  logic [5:0] sc_ops [11] = '{6'h2F, 6'h31, 6'h33, 6'h36, 6'h34, 6'h30, 6'h32, 6'h2B, 6'h2C, 6'h29, 6'h2D};
  logic [7:0] sc_exp [11] = '{8'h49, 8'h59, 8'h79, 8'h39, 8'h19, 8'h11, 8'h01, 8'h03, 8'h01, 8'h01, 8'h05};

  initial begin
    reset = 1'b1;
    wbi.wb_valid = 1'b0;
    wbi.encoded_opcode = 6'h00;
    wbi.reg_write_addr = 3'd0;
    wbi.aluout1 = 16'h0000;
    wbi.aluout2 = 16'h0000;
    wbi.statusregin = 8'h00;
    reg_read_addr = 3'd0;
    reg_read_addr2 = 3'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rs1", rs1data, 16'h0000);
    check("rst_status", 16'(statusreg), 16'h0000);
    check("rst_ready", 16'(wbi.wb_ready), 16'h0001);
    check("rst_done", 16'(wbi.wb_done), 16'h0000);
    check("rst_state", 16'(state_dbg), 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      peek("rd_zero", 3'(i), 16'h0000);
    end

    // ADD
    issue(6'h11, 3'd3, 16'h1234, 16'h0000, 8'h06);
    peek("add_r3", 3'd3, 16'h1234);
    check("add_status", 16'(statusreg), 16'h0006);
    check("add_ready", 16'(wbi.wb_ready), 16'h0001);
    check("add_done", 16'(wbi.wb_done), 16'h0001);
    tick();
    check("add_done_off", 16'(wbi.wb_done), 16'h0000);

    // MUL to r7 wraps high word into r0; a held request waits out MUL_HI
    issue(6'h21, 3'd7, 16'hBEEF, 16'h00CA, 8'h00);
    peek("mul_r7", 3'd7, 16'hBEEF);
    peek("mul_r0_old", 3'd0, 16'h0000);
    check("mul_ready_low", 16'(wbi.wb_ready), 16'h0000);
    check("mul_done_wait", 16'(wbi.wb_done), 16'h0000);
    set_in(6'h03, 3'd0, 16'h7777, 16'h0000, 8'h00);
    tick();
    peek("mul_r0_hi", 3'd0, 16'h00CA);
    check("mul_done", 16'(wbi.wb_done), 16'h0001);
    check("mul_ready_back", 16'(wbi.wb_ready), 16'h0001);
    tick();
    wbi.wb_valid = 1'b0;
    peek("held_r0", 3'd0, 16'h7777);
    check("held_done", 16'(wbi.wb_done), 16'h0001);
    tick();

    // back-to-back writes to one register
    issue(6'h04, 3'd1, 16'hAAAA, 16'h0000, 8'h00);
    issue(6'h05, 3'd1, 16'hBBBB, 16'h0000, 8'h00);
    peek("b2b_r1", 3'd1, 16'hBBBB);

    // unused opcode: no state change, still completes
    issue(6'h3A, 3'd6, 16'hFFFF, 16'hFFFF, 8'h07);
    peek("nop_r6", 3'd6, 16'h0000);
    check("nop_status", 16'(statusreg), 16'h0006);
    check("nop_done", 16'(wbi.wb_done), 16'h0001);

    // only the low three flag bits are taken
    issue(6'h11, 3'd2, 16'h0000, 16'h0000, 8'hFF);
    check("flag_mask", 16'(statusreg), 16'h0007);

    // COMP, SEI, SEC, CLZ
    issue(6'h20, 3'd5, 16'hDEAD, 16'h0000, 8'h01);
    check("comp_status", 16'(statusreg), 16'h0001);
    issue(6'h35, 3'd5, 16'hDEAD, 16'h0000, 8'h07);
    check("sei", 16'(statusreg), 16'h0041);
    issue(6'h2D, 3'd5, 16'hDEAD, 16'h0000, 8'h07);
    check("sec", 16'(statusreg), 16'h0045);
    issue(6'h2A, 3'd5, 16'hDEAD, 16'h0000, 8'h07);
    check("clz", 16'(statusreg), 16'h0044);
    peek("sc_r5", 3'd5, 16'h0000);

    // GHS
    issue(6'h03, 3'd2, 16'h5555, 16'h0000, 8'h00);
    issue(6'h16, 3'd2, 16'hFFFF, 16'h0000, 8'h01);
    peek("ghs_r2", 3'd2, 16'h5555);
    check("ghs_flags", 16'(statusreg & 8'h07), 16'h0001);
    check("ghs_status", 16'(statusreg), 16'h0041);

    for (int i = 0; i < 11; i++) begin
      issue(sc_ops[i], 3'd4, 16'h9999, 16'h0000, 8'h06);
      check("setclr_tbl", 16'(statusreg), 16'(sc_exp[i]));
    end
    peek("tbl_r4", 3'd4, 16'h0000);

    // reset during MUL_HI
    issue(6'h21, 3'd4, 16'h1111, 16'h2222, 8'h00);
    peek("mulr_r4", 3'd4, 16'h1111);
    reset = 1'b1;
    #1;
    peek("mulr_r4_clr", 3'd4, 16'h0000);
    peek("mulr_r5", 3'd5, 16'h0000);
    check("mulr_ready", 16'(wbi.wb_ready), 16'h0001);
    check("mulr_state", 16'(state_dbg), 16'h0000);
    check("mulr_done", 16'(wbi.wb_done), 16'h0000);
    tick();
    reset = 1'b0;
    tick();
    peek("mulr_r5_after", 3'd5, 16'h0000);
    check("mulr_done_after", 16'(wbi.wb_done), 16'h0000);
    tick();
    tick();
    check("done_drain", 16'(exp_q.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
